// File: rtl/present16_pkg.sv
// Shared widths, FSM encoding and round helpers for the 16-bit PRESENT-style datapath.
package present16_pkg;
   localparam int STATE_W = 16;
   localparam int KEY_W   = 32;
   localparam int KEY_ROT = 13;
   localparam int RK_HI   = 31;
   localparam int RK_LO   = 16;
   localparam int RC_HI   = 19;
   localparam int RC_LO   = 15;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   // Bit i lands on (4*i) mod 15; the top bit is a fixed point.
   function automatic logic [STATE_W-1:0] perm(input logic [STATE_W-1:0] x);
      logic [STATE_W-1:0] y;
      y = '0;
      for (int i = 0; i < STATE_W-1; i++) y[(4*i) % (STATE_W-1)] = x[i];
      y[STATE_W-1] = x[STATE_W-1];
      return y;
   endfunction

   function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] k);
      return {k[KEY_W-KEY_ROT-1:0], k[KEY_W-1:KEY_W-KEY_ROT]};
   endfunction
endpackage

// File: rtl/present16_round_ctrl_if.sv
// Handshake and substitution-layer bundle for present16_round_ctrl.
// PRESENT_ABORT_EN adds the abort input.
interface present16_round_ctrl_if;
   import present16_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_data;
   logic [KEY_W-1:0]   in_key;
   logic [STATE_W-1:0] sbox_in;
   logic [STATE_W-1:0] sbox_out;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_data;
   logic               busy;
`ifdef PRESENT_ABORT_EN
   logic               abort;

   modport slave  (input  in_valid, in_data, in_key, sbox_out, out_ready, abort,
                   output in_ready, sbox_in, out_valid, out_data, busy);
   modport master (output in_valid, in_data, in_key, sbox_out, out_ready, abort,
                   input  in_ready, sbox_in, out_valid, out_data, busy);
`else
   modport slave  (input  in_valid, in_data, in_key, sbox_out, out_ready,
                   output in_ready, sbox_in, out_valid, out_data, busy);
   modport master (output in_valid, in_data, in_key, sbox_out, out_ready,
                   input  in_ready, sbox_in, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/present16_key_sched.sv
// Key register: loads on accept, rotates by 13 and mixes the round counter each round.
module present16_key_sched
   import present16_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [KEY_W-1:0]   key_in,
   input  logic [4:0]         rnd,
   output logic [STATE_W-1:0] rkey
);
   logic [KEY_W-1:0] key;
   logic [KEY_W-1:0] key_nxt;

   always_comb begin
      key_nxt = rotl(key);
      key_nxt[RC_HI:RC_LO] = key_nxt[RC_HI:RC_LO] ^ rnd;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    key <= '0;
      else if (load) key <= key_in;
      else if (step) key <= key_nxt;
   end

   assign rkey = key[RK_HI:RK_LO];
endmodule

// File: rtl/present16_round_ctrl.sv
// Iterative PRESENT-16 round controller around an external substitution layer.
// Optional macro PRESENT_ABORT_EN adds an abort input.
module present16_round_ctrl
   import present16_pkg::*;
#(
   parameter int ROUNDS = 31
)(
   input  logic                  clk,
   input  logic                  rst_n,
   present16_round_ctrl_if.slave bus
);
   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present16_round_ctrl: ROUNDS must be within 1..31");
   end

   localparam logic [4:0] LAST = 5'(ROUNDS);

   fsm_t               st;
   fsm_t               st_nxt;
   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] rkey;
   logic [STATE_W-1:0] dout;
   logic [4:0]         rnd;
   logic               accept;
   logic               step;
   logic               abort_hit;

`ifdef PRESENT_ABORT_EN
   assign abort_hit = bus.abort && (st != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign accept = (st == IDLE) && bus.in_valid;
   assign step   = (st == ROUND) && !abort_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (bus.in_valid) st_nxt = ROUND;
         ROUND:   if (rnd == LAST) st_nxt = FINAL;
         FINAL:   st_nxt = DONE;
         DONE:    if (bus.out_ready) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
      if (abort_hit) st_nxt = IDLE;
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      case (st)
         IDLE:         bus.in_ready  = 1'b1;
         ROUND, FINAL: bus.busy      = 1'b1;
         DONE:         bus.out_valid = 1'b1;
         default:      ;
      endcase
   end

   // The substitution layer answers combinationally, so its result is permuted in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= '0;
         rnd   <= '0;
         dout  <= '0;
      end else begin
         if (accept) begin
            state <= bus.in_data;
            rnd   <= 5'd1;
         end else if (step) begin
            state <= perm(bus.sbox_out);
            rnd   <= rnd + 5'd1;
         end
         if (st == FINAL && !abort_hit) dout <= state ^ rkey;
      end
   end

   present16_key_sched u_ks (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .step   (step),
      .key_in (bus.in_key),
      .rnd    (rnd),
      .rkey   (rkey)
   );

   assign bus.sbox_in  = state ^ rkey;
   assign bus.out_data = dout;
endmodule

// File: tb/tb_present16_round_ctrl.sv
// Randomized bench for present16_round_ctrl: one ROUNDS=1 and one default instance vs a cipher model.
module tb_present16_round_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   present16_round_ctrl_if b1 ();
   present16_round_ctrl_if b31 ();

   present16_round_ctrl #(.ROUNDS(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   present16_round_ctrl               u_r31 (.clk(clk), .rst_n(rst_n), .bus(b31));

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   function automatic logic [15:0] sbox16(input logic [15:0] x);
      logic [15:0] y;
      y = '0;
      for (int n = 0; n < 4; n++) y[4*n +: 4] = SB[x[4*n +: 4]];
      return y;
   endfunction

   assign b1.sbox_out  = sbox16(b1.sbox_in);
   assign b31.sbox_out = sbox16(b31.sbox_in);

   // Whole-cipher reference: rounds of add-key, S-layer, P-layer, key update, then a final add-key.
   function automatic logic [47:0] ref_run(input logic [15:0] p, input logic [31:0] k, input int rounds);
      logic [15:0] s;
      logic [15:0] t;
      logic [31:0] kk;
      s  = p;
      kk = k;
      for (int r = 1; r <= rounds; r++) begin
         t = sbox16(s ^ kk[31:16]);
         s = '0;
         for (int i = 0; i < 16; i++) s[(i == 15) ? 15 : (4 * i) % 15] = t[i];
         kk = (kk << 13) | (kk >> 19);
         kk = kk ^ (32'(r) << 15);
      end
      return {kk, s ^ kk[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int w, input logic v, input logic [15:0] d, input logic [31:0] k);
      if (w == 0) begin b1.in_valid = v;  b1.in_data = d;  b1.in_key = k;  end
      else        begin b31.in_valid = v; b31.in_data = d; b31.in_key = k; end
   endtask

   task automatic set_ordy(input int w, input logic r);
      if (w == 0) b1.out_ready = r;
      else        b31.out_ready = r;
   endtask

   function automatic logic ovalid(input int w);
      return (w == 0) ? b1.out_valid : b31.out_valid;
   endfunction
   function automatic logic iready(input int w);
      return (w == 0) ? b1.in_ready : b31.in_ready;
   endfunction
   function automatic logic obusy(input int w);
      return (w == 0) ? b1.busy : b31.busy;
   endfunction
   function automatic logic [15:0] odata(input int w);
      return (w == 0) ? b1.out_data : b31.out_data;
   endfunction
   function automatic logic [15:0] sbin(input int w);
      return (w == 0) ? b1.sbox_in : b31.sbox_in;
   endfunction

   // Offer one block, measure edges from accept to out_valid, hold it, then pop it.
   task automatic run_block(input int w, input logic [15:0] d, input logic [31:0] k, input int hold,
                            output int lat, output logic [15:0] q, output logic [15:0] sb0);
      @(negedge clk);
      chk("acc_ready", iready(w), 1);
      drive(w, 1'b1, d, k);
      @(negedge clk);
      drive(w, 1'b0, 16'($urandom), $urandom);
      sb0 = sbin(w);
      lat = 0;
      while (!ovalid(w) && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      q = odata(w);
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk("hold_data", odata(w), q);
      end
      set_ordy(w, 1'b1);
      @(negedge clk);
      set_ordy(w, 1'b0);
      chk("pop_valid", ovalid(w), 0);
      chk("pop_ready", iready(w), 1);
   endtask

   initial begin
      int          lat;
      int          seen;
      logic [15:0] q;
      logic [15:0] sb;
      logic [15:0] d;
      logic [31:0] k;
      logic [47:0] r;

      rst_n = 1'b0;
      drive(0, 1'b0, 16'h0, 32'h0);
      drive(1, 1'b0, 16'h0, 32'h0);
      set_ordy(0, 1'b0);
      set_ordy(1, 1'b0);
`ifdef PRESENT_ABORT_EN
      b1.abort  = 1'b0;
      b31.abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         chk("rst_ready", iready(w), 1);
         chk("rst_valid", ovalid(w), 0);
         chk("rst_busy", obusy(w), 0);
         chk("rst_data", odata(w), 0);
      end
      rst_n = 1'b1;

      // ROUNDS=1, zero key and data: S(0)=C everywhere, P(CCCC)=FF00
      run_block(0, 16'h0000, 32'h0, 0, lat, q, sb);
      chk("t1_sbox", sb, 16'h0000);
      chk("t1_lat", lat, 2);
      chk("t1_data", q, 16'hFF00);

      // ROUNDS=1, key FFFF0000: final key is rotl13 with bit15 flipped = E0009FFF
      run_block(0, 16'hFFFF, 32'hFFFF_0000, 0, lat, q, sb);
      r = ref_run(16'hFFFF, 32'hFFFF_0000, 1);
      chk("t2_sbox", sb, 16'h0000);
      chk("t2_lat", lat, 2);
      chk("t2_key", u_r1.u_ks.key, 32'hE000_9FFF);
      chk("t2_key_ref", u_r1.u_ks.key, r[47:16]);
      chk("t2_data", q, 16'hFF00 ^ 16'hE000);

      // Backpressure with an ignored in_valid pulse
      @(negedge clk);
      drive(0, 1'b1, 16'h5A5A, 32'h0123_4567);
      @(negedge clk);
      drive(0, 1'b0, 16'h0, 32'h0);
      lat = 0;
      while (!ovalid(0) && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      r = ref_run(16'h5A5A, 32'h0123_4567, 1);
      q = odata(0);
      chk("bp_lat", lat, 2);
      chk("bp_first", q, r[15:0]);
      for (int c = 0; c < 10; c++) begin
         if (c == 4)      drive(0, 1'b1, 16'h1234, 32'hDEAD_BEEF);
         else if (c == 5) drive(0, 1'b0, 16'h0, 32'h0);
         chk("bp_valid", ovalid(0), 1);
         chk("bp_data", odata(0), r[15:0]);
         chk("bp_ready", iready(0), 0);
         @(negedge clk);
      end
      set_ordy(0, 1'b1);
      @(negedge clk);
      set_ordy(0, 1'b0);
      chk("bp_pop_valid", ovalid(0), 0);
      chk("bp_pop_ready", iready(0), 1);
      chk("bp_pop_busy", obusy(0), 0);

      // Default ROUNDS=31, random blocks with random consumer stalls
      for (int b = 0; b < 32; b++) begin
         d = 16'($urandom);
         k = $urandom;
         r = ref_run(d, k, 31);
         run_block(1, d, k, int'($urandom_range(0, 3)), lat, q, sb);
         chk("rnd_lat", lat, 32);
         chk("rnd_data", q, r[15:0]);
      end

      // Reset in the middle of round 10
      @(negedge clk);
      drive(1, 1'b1, 16'hBEEF, 32'hCAFE_F00D);
      @(negedge clk);
      drive(1, 1'b0, 16'h0, 32'h0);
      repeat (9) @(negedge clk);
      chk("mid_rnd", 32'(u_r31.rnd), 10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_ready", iready(1), 1);
      chk("mid_busy", obusy(1), 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (ovalid(1)) seen++;
         @(negedge clk);
      end
      chk("mid_no_valid", seen, 0);
      d = 16'($urandom);
      k = $urandom;
      r = ref_run(d, k, 31);
      run_block(1, d, k, 1, lat, q, sb);
      chk("mid_next_lat", lat, 32);
      chk("mid_next_data", q, r[15:0]);

`ifdef PRESENT_ABORT_EN
      // Abort during round 5
      @(negedge clk);
      drive(1, 1'b1, 16'h1357, 32'h2468_ACE0);
      @(negedge clk);
      drive(1, 1'b0, 16'h0, 32'h0);
      repeat (4) @(negedge clk);
      chk("ab_rnd", 32'(u_r31.rnd), 5);
      b31.abort = 1'b1;
      @(negedge clk);
      b31.abort = 1'b0;
      chk("ab_ready", iready(1), 1);
      chk("ab_valid", ovalid(1), 0);
      chk("ab_busy", obusy(1), 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (ovalid(1)) seen++;
         @(negedge clk);
      end
      chk("ab_no_valid", seen, 0);

      // Abort in DONE wins over out_ready
      @(negedge clk);
      drive(1, 1'b1, 16'h0F0F, 32'h1111_2222);
      @(negedge clk);
      drive(1, 1'b0, 16'h0, 32'h0);
      lat = 0;
      while (!ovalid(1) && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk("abd_lat", lat, 32);
      b31.abort = 1'b1;
      set_ordy(1, 1'b1);
      @(negedge clk);
      b31.abort = 1'b0;
      set_ordy(1, 1'b0);
      chk("abd_valid", ovalid(1), 0);
      chk("abd_ready", iready(1), 1);

      d = 16'($urandom);
      k = $urandom;
      r = ref_run(d, k, 31);
      run_block(1, d, k, 0, lat, q, sb);
      chk("ab_next_data", q, r[15:0]);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d vectors", n_vec);
      $fatal(1, "watchdog");
   end
endmodule
